axi4_lite_slave_responder: RTL

- Parametrised AXI4-Lite slave responder backed by a word-addressed memory.
- Independent write (AW+W→B) and read (AR→R) engines with run-time programmable ready-delay.
- Address decode produces OKAY, SLVERR or DECERR responses.
- Sits at the slave side of the AXI4-Lite environment as the synthesizable DUT/reference target that the master agent drives.

---
 rtl/axi4_lite_responder_pkg.sv | 49 ++++
 rtl/axi4_lite_ready_delay.sv | 36 +++
 rtl/axi4_lite_slave_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_responder_pkg.sv
// Shared types for the AXI4-Lite slave responder: response codes,
// engine state encodings and the address decode function.
package axi4_lite_responder_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DELAY,
        W_ACCEPT,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_ACCEPT,
        R_RESP
    } rstate_e;

    // The extra top bit of diff is the borrow: addresses below the base
    // never alias onto high words.
    function automatic resp_e decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned depth,
        input int unsigned strb
    );
        logic [64:0] diff;
        logic [63:0] idx;
        logic [63:0] mask;
        diff = {1'b0, addr} - {1'b0, base};
        idx  = diff[63:0] >> ((strb == 8) ? 3 : 2);
        mask = 64'(strb) - 64'd1;
        if (diff[64])
            return RESP_DECERR;
        if (idx >= 64'(depth))
            return RESP_DECERR;
        if ((addr & mask) != 64'd0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_ready_delay.sv
// Ready-delay counter: loaded with a cycle count, decremented while the
// engine waits; done_o flags the last wait cycle (count of one).
module axi4_lite_ready_delay #(
    parameter int unsigned DELAY_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [DELAY_WIDTH-1:0] delay_i,
    input  logic                   dec_i,
    output logic                   done_o
);

    localparam logic [DELAY_WIDTH-1:0] ONE = DELAY_WIDTH'(1);

    logic [DELAY_WIDTH-1:0] cnt_q;
    logic [DELAY_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = delay_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite slave backed by a word memory; independent write/read engines
// with programmable ready delay. Optional macro: AXI4_LITE_PROT_CHECK_EN.
module axi4_lite_slave_responder
    import axi4_lite_responder_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH     = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned DELAY_WIDTH   = 5,
    localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_WIDTH-1:0]    wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [DELAY_WIDTH-1:0]   cfg_write_ready_delay,
    input  logic [DELAY_WIDTH-1:0]   cfg_read_ready_delay
);

    localparam int unsigned LG   = $clog2(STRB_WIDTH);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wstate_e               w_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    resp_e                 bresp_q;

    rstate_e               r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    resp_e                 rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    resp_e                 wresp;
    resp_e                 rresp_c;
    logic [ADDRESS_WIDTH-1:0] woff;
    logic [ADDRESS_WIDTH-1:0] roff;
    logic [IDXW-1:0]       widx;
    logic [IDXW-1:0]       ridx;
    logic                  w_load;
    logic                  r_load;
    logic                  w_done;
    logic                  r_done;

    assign woff = awaddr - BASE_ADDR;
    assign roff = araddr - BASE_ADDR;
    assign widx = woff[LG +: IDXW];
    assign ridx = roff[LG +: IDXW];

    always_comb begin
        wresp = decode(64'(awaddr), 64'(BASE_ADDR), MEM_DEPTH, STRB_WIDTH);
`ifdef AXI4_LITE_PROT_CHECK_EN
        if (wresp == RESP_OKAY && awprot[1])
            wresp = RESP_SLVERR;
`endif
    end

    always_comb begin
        rresp_c = decode(64'(araddr), 64'(BASE_ADDR), MEM_DEPTH, STRB_WIDTH);
`ifdef AXI4_LITE_PROT_CHECK_EN
        if (rresp_c == RESP_OKAY && arprot[1])
            rresp_c = RESP_SLVERR;
`endif
    end

    logic unused_w;
    assign unused_w = ^{woff, roff, awprot, arprot};

    assign w_load = (w_state_q == W_IDLE) && awvalid && wvalid;
    assign r_load = (r_state_q == R_IDLE) && arvalid;

    axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH)) u_wdly (
        .clk_i   (aclk),
        .rst_i   (areset),
        .load_i  (w_load),
        .delay_i (cfg_write_ready_delay),
        .dec_i   (w_state_q == W_DELAY),
        .done_o  (w_done)
    );

    axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH)) u_rdly (
        .clk_i   (aclk),
        .rst_i   (areset),
        .load_i  (r_load),
        .delay_i (cfg_read_ready_delay),
        .dec_i   (r_state_q == R_DELAY),
        .done_o  (r_done)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (w_load) begin
                        if (cfg_write_ready_delay != '0) begin
                            w_state_q <= W_DELAY;
                        end else begin
                            w_state_q <= W_ACCEPT;
                            awready_q <= 1'b1;
                            wready_q  <= 1'b1;
                        end
                    end
                end
                W_DELAY: begin
                    if (w_done) begin
                        w_state_q <= W_ACCEPT;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_ACCEPT: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wresp;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Memory is not reset; a reset edge in W_ACCEPT suppresses the commit.
    always_ff @(posedge aclk) begin
        if (!areset && w_state_q == W_ACCEPT && wresp == RESP_OKAY) begin
            for (int i = 0; i < int'(STRB_WIDTH); i++) begin
                if (wstrb[i])
                    mem_q[widx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Sampling here with the write's non-blocking update gives
    // read-before-write when both accept in the same cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (r_load) begin
                        if (cfg_read_ready_delay != '0) begin
                            r_state_q <= R_DELAY;
                        end else begin
                            r_state_q <= R_ACCEPT;
                            arready_q <= 1'b1;
                        end
                    end
                end
                R_DELAY: begin
                    if (r_done) begin
                        r_state_q <= R_ACCEPT;
                        arready_q <= 1'b1;
                    end
                end
                R_ACCEPT: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rresp_q   <= rresp_c;
                    rdata_q   <= (rresp_c == RESP_OKAY) ? mem_q[ridx] : '0;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule
